// File: rtl/fifo_serial_tx.sv
// Serial transmitter that pops one word at a time from an upstream synchronous FIFO
// and sends it as a start bit, Width data bits LSB-first, and a stop bit.
module fifo_serial_tx #(
   parameter int Width      = 16,
   parameter int ClksPerBit = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             fifo_empty,
   input  logic [Width-1:0] fifo_dout,
   output logic             fifo_r_enb,
   output logic             tx,
   output logic             busy,
   output logic             done,
   output logic [15:0]      frame_cnt
);

   localparam int BaudW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
   localparam int BitW  = $clog2(Width) + 1;
   localparam logic [BaudW-1:0] BaudLast = BaudW'(ClksPerBit - 1);
   localparam logic [BitW-1:0]  BitLast  = BitW'(Width - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      LOAD  = 3'd2,
      START = 3'd3,
      DATA  = 3'd4,
      STOP  = 3'd5
   } state_t;

   state_t             state_q;
   logic [BaudW-1:0]   baud_q;
   logic [BitW-1:0]    bit_q;
   logic [Width-1:0]   shift_q;
   logic               tx_q;
   logic               rd_q;
   logic               busy_q;
   logic               done_q;
   logic [15:0]        cnt_q;

   logic               start_ok_d;
   logic               baud_end_d;

   assign start_ok_d = enable & ~fifo_empty;
   assign baud_end_d = (baud_q == BaudLast);

   // Frame sequencer: every output is a register updated alongside the state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         rd_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= 16'd0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               baud_q <= '0;
               bit_q  <= '0;
               tx_q   <= 1'b1;
               if (start_ok_d) begin
                  state_q <= READ;
                  rd_q    <= 1'b1;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= IDLE;
                  rd_q    <= 1'b0;
                  busy_q  <= 1'b0;
               end
            end
            READ: begin
               rd_q    <= 1'b0;
               state_q <= LOAD;
            end
            // The FIFO presents the popped word during this cycle.
            LOAD: begin
               shift_q <= fifo_dout;
               tx_q    <= 1'b0;
               baud_q  <= '0;
               state_q <= START;
            end
            START: begin
               if (baud_end_d) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  tx_q    <= shift_q[0];
                  shift_q <= shift_q >> 1;
                  state_q <= DATA;
               end else begin
                  baud_q <= baud_q + BaudW'(1);
               end
            end
            DATA: begin
               if (baud_end_d) begin
                  baud_q <= '0;
                  if (bit_q == BitLast) begin
                     tx_q    <= 1'b1;
                     state_q <= STOP;
                  end else begin
                     bit_q   <= bit_q + BitW'(1);
                     tx_q    <= shift_q[0];
                     shift_q <= shift_q >> 1;
                  end
               end else begin
                  baud_q <= baud_q + BaudW'(1);
               end
            end
            // Chaining straight into READ leaves exactly two idle-high cycles between frames.
            STOP: begin
               if (baud_end_d) begin
                  baud_q <= '0;
                  done_q <= 1'b1;
                  cnt_q  <= cnt_q + 16'd1;
                  if (start_ok_d) begin
                     state_q <= READ;
                     rd_q    <= 1'b1;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                     rd_q    <= 1'b0;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  baud_q <= baud_q + BaudW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               tx_q    <= 1'b1;
               rd_q    <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign fifo_r_enb = rd_q;
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench for fifo_serial_tx (Width=16, ClksPerBit=4) with a small FIFO model.
module tb_fifo_serial_tx;
   localparam int W = 16;
   localparam int C = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          fifo_empty;
   logic [W-1:0]  fifo_dout = '0;
   logic          fifo_r_enb;
   logic          tx;
   logic          busy;
   logic          done;
   logic [15:0]   frame_cnt;

   int n_vec = 0;
   int n_err = 0;

   logic [W-1:0] mem [0:15];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int rd_pulses = 0;
   int done_pulses = 0;
   int bad_reads = 0;

   always #5 clk = ~clk;

   fifo_serial_tx #(.Width(W), .ClksPerBit(C)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_r_enb (fifo_r_enb),
      .tx         (tx),
      .busy       (busy),
      .done       (done),
      .frame_cnt  (frame_cnt)
   );

   assign fifo_empty = (wr_ptr == rd_ptr);

   // Upstream FIFO: registered read data, plus strobe/pulse tallies.
   always @(posedge clk) begin
      if (fifo_r_enb === 1'b1) begin
         rd_pulses <= rd_pulses + 1;
         if (wr_ptr != rd_ptr) begin
            fifo_dout <= mem[rd_ptr % 16];
            rd_ptr    <= rd_ptr + 1;
         end else begin
            bad_reads <= bad_reads + 1;
         end
      end
      if (done === 1'b1) done_pulses <= done_pulses + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [W-1:0] w);
      mem[wr_ptr % 16] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   // Follows one frame from its read strobe; optionally drops enable or pulses reset mid-frame.
   task automatic run_frame(input logic [W-1:0] word, input logic [15:0] exp_cnt,
                            input bit more, input int drop_i, input int rst_i);
      int guard;
      int busy_n;
      logic exp_bit;
      guard = 0;
      busy_n = 0;
      while (fifo_r_enb !== 1'b1 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      chk("read_strobe", 32'(fifo_r_enb), 32'd1);
      if (fifo_r_enb !== 1'b1) return;
      chk("read_tx", 32'(tx), 32'd1);
      busy_n += int'(busy);
      @(negedge clk);
      chk("load_rd", 32'(fifo_r_enb), 32'd0);
      chk("load_tx", 32'(tx), 32'd1);
      chk("load_done", 32'(done), 32'd0);
      busy_n += int'(busy);
      for (int i = 0; i < (W + 2) * C; i++) begin
         @(negedge clk);
         if (i < C) exp_bit = 1'b0;
         else if (i < (W + 1) * C) exp_bit = word[(i - C) / C];
         else exp_bit = 1'b1;
         chk($sformatf("tx_cyc%0d", i), 32'(tx), 32'(exp_bit));
         chk("frame_rd", 32'(fifo_r_enb), 32'd0);
         chk("frame_done", 32'(done), 32'd0);
         busy_n += int'(busy);
         if (i == drop_i) enable = 1'b0;
         if (i == rst_i) begin
            reset = 1'b0;
            @(negedge clk);
            chk("rst_tx", 32'(tx), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_cnt", 32'(frame_cnt), 32'(exp_cnt));
            reset = 1'b1;
            return;
         end
      end
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd1);
      chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
      chk("next_rd", 32'(fifo_r_enb), 32'(more));
      chk("next_busy", 32'(busy), 32'(more));
      chk("busy_cycles", 32'(busy_n), 32'd74);
      if (!more) begin
         @(negedge clk);
         chk("done_once", 32'(done), 32'd0);
      end
   endtask

   initial begin
      int rp0;
      int dp0;
      reset = 1'b0;
      enable = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_tx0", 32'(tx), 32'd1);
      chk("rst_rd0", 32'(fifo_r_enb), 32'd0);
      chk("rst_busy0", 32'(busy), 32'd0);
      chk("rst_done0", 32'(done), 32'd0);
      chk("rst_cnt0", 32'(frame_cnt), 32'd0);

      reset = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("empty_rd", 32'(fifo_r_enb), 32'd0);
         chk("empty_busy", 32'(busy), 32'd0);
      end
      chk("empty_pulses", 32'(rd_pulses), 32'd0);

      rp0 = rd_pulses;
      dp0 = done_pulses;
      push(16'hA5C3);
      run_frame(16'hA5C3, 16'd1, 1'b0, -1, -1);
      chk("a5c3_reads", 32'(rd_pulses - rp0), 32'd1);
      chk("a5c3_dones", 32'(done_pulses - dp0), 32'd1);

      rp0 = rd_pulses;
      dp0 = done_pulses;
      push(16'h0001);
      push(16'hFFFF);
      run_frame(16'h0001, 16'd2, 1'b1, -1, -1);
      run_frame(16'hFFFF, 16'd3, 1'b0, -1, -1);
      chk("b2b_reads", 32'(rd_pulses - rp0), 32'd2);
      chk("b2b_dones", 32'(done_pulses - dp0), 32'd2);

      rp0 = rd_pulses;
      push(16'h1234);
      push(16'h5678);
      push(16'h9ABC);
      run_frame(16'h1234, 16'd4, 1'b0, C + 5 * C + 1, -1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("drop_rd", 32'(fifo_r_enb), 32'd0);
         chk("drop_busy", 32'(busy), 32'd0);
         chk("drop_tx", 32'(tx), 32'd1);
      end
      chk("drop_reads", 32'(rd_pulses - rp0), 32'd1);

      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst2_cnt", 32'(frame_cnt), 32'd0);
      chk("rst2_rd", 32'(fifo_r_enb), 32'd0);
      reset = 1'b1;
      enable = 1'b1;
      dp0 = done_pulses;
      run_frame(16'h5678, 16'd0, 1'b0, -1, C + 8 * C + 1);
      chk("rst_no_done", 32'(done_pulses - dp0), 32'd0);
      run_frame(16'h9ABC, 16'd1, 1'b0, -1, -1);
      chk("bad_reads", 32'(bad_reads), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_serial_tx.md
FIFO_SERIAL_TX -- requirements
Module: fifo_serial_tx

Interface
REQ-001 The block SHALL have parameter Width, default 16, giving the FIFO word width and the data bits per frame.
REQ-002 The block SHALL have parameter ClksPerBit, default 4, giving clock cycles per serial bit period; legal range >=1.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 enable  input  1  permits starting new frames; a frame in progress always completes.
REQ-006 fifo_empty  input  1  empty flag of the upstream synchronous FIFO.
REQ-007 fifo_dout  input  Width  upstream FIFO registered read data, valid the cycle after a read is sampled.
REQ-008 fifo_r_enb  output  1  registered FIFO read strobe.
REQ-009 tx  output  1  registered serial line, idle high.
REQ-010 busy  output  1  high in every FSM state except IDLE.
REQ-011 done  output  1  one-cycle pulse per completed frame.
REQ-012 frame_cnt  output  16  count of completed frames.

Function
REQ-013 FSM states SHALL be IDLE, READ, LOAD, START, DATA and STOP.
REQ-014 IDLE:
- if enable=1 and fifo_empty=0 at an edge -> READ with fifo_r_enb=1;
- else remain IDLE with tx=1.
REQ-015 READ SHALL last exactly one cycle, with fifo_r_enb=1 only in this state; next state LOAD with fifo_r_enb=0.
REQ-016 LOAD SHALL last one cycle; at its closing edge fifo_dout is captured into a Width-bit shift register, tx<=0 and state -> START.
REQ-017 Latency: tx SHALL go low 3 edges after the edge sampling enable=1 and fifo_empty=0 in IDLE.
REQ-018 START SHALL hold tx=0 for ClksPerBit cycles.
REQ-019 DATA SHALL send Width bits LSB-first, ClksPerBit cycles each, counted by a $clog2(Width)+1-bit bit counter.
REQ-020 STOP SHALL hold tx=1 for ClksPerBit cycles.
REQ-021 Frame length SHALL be (Width+2)*ClksPerBit cycles from the first start-bit cycle to the last stop-bit cycle.
REQ-022 The baud counter SHALL count 0..ClksPerBit-1 and reload to 0 at each bit boundary; ClksPerBit=1 gives one cycle per bit.
REQ-023 On the edge ending STOP:
- done<=1 for one cycle;
- frame_cnt<=frame_cnt+1, wrapping 16'hFFFF -> 0.
REQ-024 On that same edge, next state SHALL be READ if enable=1 and fifo_empty=0, else IDLE, giving exactly 2 idle-high cycles between back-to-back frames.
REQ-025 fifo_empty and enable SHALL be ignored in every state except IDLE and the last STOP cycle.
REQ-026 At most one read SHALL be issued per frame, and no read while fifo_empty=1.
REQ-027 Deasserting enable mid-frame SHALL NOT truncate the frame or alter tx timing.

Reset
REQ-028 With reset=0 at an edge, the block SHALL force:
- state=IDLE, tx=1, fifo_r_enb=0, busy=0, done=0, frame_cnt=0;
- baud counter, bit counter and shift register=0.
REQ-029 Reset asserted mid-frame (any state) SHALL abandon the frame: tx=1 from the next cycle, no done pulse, no frame_cnt increment; a word already popped is lost.
REQ-030 After reset release, no read SHALL be issued earlier than the first edge with reset=1, enable=1 and fifo_empty=0.

Verification (Width=16, ClksPerBit=4, bench models the upstream FIFO)
REQ-031 Reset held 2 cycles -> tx=1, fifo_r_enb=0, busy=0, done=0, frame_cnt=0; with enable=1 and fifo_empty=1 for 20 cycles -> fifo_r_enb stays 0, busy=0.
REQ-032 Single word 16'hA5C3, enable=1:
- fifo_r_enb high exactly 1 cycle; tx low 3 edges later for 4 cycles;
- then data bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, 4 cycles each; then 4 stop cycles high;
- done pulses once, frame_cnt=1, busy high 74 cycles total.
REQ-033 Words 16'h0001 then 16'hFFFF back-to-back -> tx high exactly 2 cycles between stop end and the second start bit; two done pulses, frame_cnt=2, exactly two fifo_r_enb pulses.
REQ-034 enable dropped during DATA bit 5 with 3 words queued -> current frame completes bit-exact, done pulses, no further fifo_r_enb, busy=0.
REQ-035 reset=0 for 1 cycle during DATA bit 8 -> tx=1 and busy=0 next cycle, no done, frame_cnt unchanged; after release the next queued word sends as a full, correct frame.
